ra_stack_ctrl: RTL and testbench

Return-address stack controller for the 8-bit computer's call/return path. It replaces the single return-address register with a small circular stack of return addresses. It pushes on `jal`, pops on `jr`, and presents the current top-of-stack to the PC mux. On the `print_regs` syscall it sequences a one-entry-per-cycle dump of the stack to the debug/print port, holding off call/return traffic until the dump finishes.

---
 rtl/ra_stack_ctrl.sv | 115 +++++++++++
 tb/tb_ra_stack_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_stack_ctrl.sv
// Circular return-address stack: push on jal, pop on jr, top-of-stack visible the cycle after the update.
// print_regs dumps one entry per cycle; ready drops and jal/jr are ignored until the dump ends.
module ra_stack_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       jal,
   input  logic                       jr,
   input  logic [ADDR_W-1:0]          write_data_ra,
   output logic [ADDR_W-1:0]          read_data_ra,
   output logic                       ra_valid,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       ready,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       print_regs,
   output logic                       print_valid,
   output logic [$clog2(DEPTH)-1:0]   print_idx,
   output logic [ADDR_W-1:0]          print_data,
   output logic                       print_done
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wp, wp_nxt, wp_m1, k, rd_idx, wr_idx;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              wr_en, ovf_set, unf_set;

   assign wp_m1  = wp - 1'b1;
   assign rd_idx = wp_m1 - k;

   // Stack update for this cycle; only meaningful when the FSM is idle.
   always_comb begin
      wp_nxt  = wp;
      cnt_nxt = cnt;
      wr_en   = 1'b0;
      wr_idx  = wp;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (state == IDLE) begin
         if (jal && (!jr || cnt == '0)) begin
            wr_en  = 1'b1;
            wp_nxt = wp + 1'b1;
            if (cnt == FULL) ovf_set = 1'b1;
            else             cnt_nxt = cnt + 1'b1;
         end else if (jal && jr) begin
            wr_en  = 1'b1;
            wr_idx = wp_m1;
         end else if (jr) begin
            if (cnt != '0) begin
               wp_nxt  = wp_m1;
               cnt_nxt = cnt - 1'b1;
            end else begin
               unf_set = 1'b1;
            end
         end
      end
   end

   always_comb begin
      next_state  = state;
      print_valid = 1'b0;
      print_idx   = '0;
      print_data  = '0;
      print_done  = 1'b0;
      case (state)
         IDLE: if (print_regs) next_state = (cnt_nxt == '0) ? DONE : DUMP;
         DUMP: begin
            print_valid = 1'b1;
            print_idx   = k;
            print_data  = mem[rd_idx];
            if ({1'b0, k} == cnt - 1'b1) next_state = DONE;
         end
         DONE: begin
            print_done = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wp        <= '0;
         cnt       <= '0;
         k         <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= next_state;
         wp    <= wp_nxt;
         cnt   <= cnt_nxt;
         k     <= (state == DUMP) ? k + 1'b1 : '0;
         if (wr_en)   mem[wr_idx] <= write_data_ra;
         if (ovf_set) overflow    <= 1'b1;
         if (unf_set) underflow   <= 1'b1;
      end
   end

   assign read_data_ra = (cnt != '0) ? mem[wp_m1] : '0;
   assign ra_valid     = (cnt != '0);
   assign depth        = cnt;
   assign ready        = (state == IDLE);

endmodule

// File: tb/tb_ra_stack_ctrl.sv
// Directed bench for ra_stack_ctrl: push/pop, overflow, underflow, tail call, dump sequencing.
module tb_ra_stack_ctrl;

   logic       clk = 1'b0;
   logic       reset, jal, jr, print_regs;
   logic [2:0] write_data_ra;
   logic [2:0] read_data_ra, print_data;
   logic [2:0] depth;
   logic [1:0] print_idx;
   logic       ra_valid, ready, overflow, underflow, print_valid, print_done;

   int errors = 0;
   int checks = 0;

   ra_stack_ctrl #(.ADDR_W(3), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .jal(jal), .jr(jr), .write_data_ra(write_data_ra),
      .read_data_ra(read_data_ra), .ra_valid(ra_valid), .depth(depth), .ready(ready),
      .overflow(overflow), .underflow(underflow), .print_regs(print_regs),
      .print_valid(print_valid), .print_idx(print_idx), .print_data(print_data),
      .print_done(print_done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic push(input logic [2:0] v);
      jal = 1'b1; write_data_ra = v;
      cyc();
      jal = 1'b0;
   endtask

   task automatic pop();
      jr = 1'b1;
      cyc();
      jr = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 10;
      if (read_data_ra !== 3'd0) begin errors++; $display("FAIL rst_rd got=%0d exp=0", read_data_ra); end
      if (ra_valid !== 1'b0)     begin errors++; $display("FAIL rst_valid got=%b exp=0", ra_valid); end
      if (depth !== 3'd0)        begin errors++; $display("FAIL rst_depth got=%0d exp=0", depth); end
      if (ready !== 1'b1)        begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
      if (overflow !== 1'b0)     begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
      if (underflow !== 1'b0)    begin errors++; $display("FAIL rst_unf got=%b exp=0", underflow); end
      if (print_valid !== 1'b0)  begin errors++; $display("FAIL rst_pv got=%b exp=0", print_valid); end
      if (print_done !== 1'b0)   begin errors++; $display("FAIL rst_pd got=%b exp=0", print_done); end
      if (print_idx !== 2'd0)    begin errors++; $display("FAIL rst_pidx got=%0d exp=0", print_idx); end
      if (print_data !== 3'd0)   begin errors++; $display("FAIL rst_pdata got=%0d exp=0", print_data); end
   endtask

   task automatic test_push_pop();
      logic [2:0] exp_rd [3];
      exp_rd = '{3'd3, 3'd5, 3'd0};
      do_reset();
      push(3'd5); push(3'd3); push(3'd6);
      checks += 2;
      if (depth !== 3'd3)        begin errors++; $display("FAIL pp_depth got=%0d exp=3", depth); end
      if (read_data_ra !== 3'd6) begin errors++; $display("FAIL pp_top got=%0d exp=6", read_data_ra); end
      for (int i = 0; i < 3; i++) begin
         pop();
         checks++;
         if (read_data_ra !== exp_rd[i])
            begin errors++; $display("FAIL pp_pop%0d got=%0d exp=%0d", i, read_data_ra, exp_rd[i]); end
      end
      checks++;
      if (ra_valid !== 1'b0) begin errors++; $display("FAIL pp_valid got=%b exp=0", ra_valid); end
   endtask

   task automatic test_overflow();
      logic [2:0] exp_rd [4];
      exp_rd = '{3'd4, 3'd3, 3'd2, 3'd0};
      do_reset();
      push(3'd1); push(3'd2); push(3'd3); push(3'd4);
      checks += 2;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      if (depth !== 3'd4)    begin errors++; $display("FAIL ovf_full got=%0d exp=4", depth); end
      push(3'd7);
      checks += 3;
      if (overflow !== 1'b1)     begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      if (depth !== 3'd4)        begin errors++; $display("FAIL ovf_depth got=%0d exp=4", depth); end
      if (read_data_ra !== 3'd7) begin errors++; $display("FAIL ovf_top got=%0d exp=7", read_data_ra); end
      for (int i = 0; i < 4; i++) begin
         pop();
         checks++;
         if (read_data_ra !== exp_rd[i])
            begin errors++; $display("FAIL ovf_pop%0d got=%0d exp=%0d", i, read_data_ra, exp_rd[i]); end
      end
      checks += 2;
      if (depth !== 3'd0)     begin errors++; $display("FAIL ovf_empty got=%0d exp=0", depth); end
      if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_unf got=%b exp=0", underflow); end
   endtask

   task automatic test_underflow();
      do_reset();
      pop();
      checks += 3;
      if (underflow !== 1'b1)    begin errors++; $display("FAIL unf_flag got=%b exp=1", underflow); end
      if (depth !== 3'd0)        begin errors++; $display("FAIL unf_depth got=%0d exp=0", depth); end
      if (read_data_ra !== 3'd0) begin errors++; $display("FAIL unf_rd got=%0d exp=0", read_data_ra); end
      push(3'd2); push(3'd6);
      checks += 3;
      if (underflow !== 1'b1)    begin errors++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
      if (depth !== 3'd2)        begin errors++; $display("FAIL unf_depth2 got=%0d exp=2", depth); end
      if (read_data_ra !== 3'd6) begin errors++; $display("FAIL unf_top got=%0d exp=6", read_data_ra); end
      do_reset();
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", underflow); end
   endtask

   task automatic test_tail_call();
      do_reset();
      push(3'd2); push(3'd5);
      jal = 1'b1; jr = 1'b1; write_data_ra = 3'd7;
      cyc();
      jal = 1'b0; jr = 1'b0;
      checks += 2;
      if (depth !== 3'd2)        begin errors++; $display("FAIL tc_depth got=%0d exp=2", depth); end
      if (read_data_ra !== 3'd7) begin errors++; $display("FAIL tc_top got=%0d exp=7", read_data_ra); end
      pop();
      checks++;
      if (read_data_ra !== 3'd2) begin errors++; $display("FAIL tc_pop got=%0d exp=2", read_data_ra); end
      do_reset();
      jal = 1'b1; jr = 1'b1; write_data_ra = 3'd4;
      cyc();
      jal = 1'b0; jr = 1'b0;
      checks += 3;
      if (depth !== 3'd1)        begin errors++; $display("FAIL tce_depth got=%0d exp=1", depth); end
      if (read_data_ra !== 3'd4) begin errors++; $display("FAIL tce_top got=%0d exp=4", read_data_ra); end
      if (underflow !== 1'b0)    begin errors++; $display("FAIL tce_unf got=%b exp=0", underflow); end
   endtask

   task automatic test_dump();
      logic [2:0] exp_d [3];
      exp_d = '{3'd3, 3'd2, 3'd1};
      do_reset();
      push(3'd1); push(3'd2); push(3'd3);
      print_regs = 1'b1;
      cyc();
      print_regs = 1'b0;
      jal = 1'b1; write_data_ra = 3'd6;
      for (int i = 0; i < 3; i++) begin
         checks += 4;
         if (print_valid !== 1'b1) begin errors++; $display("FAIL dmp_pv%0d got=%b exp=1", i, print_valid); end
         if (print_idx !== 2'(i))  begin errors++; $display("FAIL dmp_idx%0d got=%0d exp=%0d", i, print_idx, i); end
         if (print_data !== exp_d[i])
            begin errors++; $display("FAIL dmp_data%0d got=%0d exp=%0d", i, print_data, exp_d[i]); end
         if (ready !== 1'b0) begin errors++; $display("FAIL dmp_rdy%0d got=%b exp=0", i, ready); end
         cyc();
      end
      checks += 3;
      if (print_done !== 1'b1)  begin errors++; $display("FAIL dmp_done got=%b exp=1", print_done); end
      if (print_valid !== 1'b0) begin errors++; $display("FAIL dmp_pvend got=%b exp=0", print_valid); end
      if (ready !== 1'b0)       begin errors++; $display("FAIL dmp_rdydone got=%b exp=0", ready); end
      cyc();
      jal = 1'b0;
      checks += 4;
      if (print_done !== 1'b0)   begin errors++; $display("FAIL dmp_pulse got=%b exp=0", print_done); end
      if (ready !== 1'b1)        begin errors++; $display("FAIL dmp_rdyback got=%b exp=1", ready); end
      if (depth !== 3'd3)        begin errors++; $display("FAIL dmp_depth got=%0d exp=3", depth); end
      if (read_data_ra !== 3'd3) begin errors++; $display("FAIL dmp_top got=%0d exp=3", read_data_ra); end
   endtask

   task automatic test_dump_reset();
      print_regs = 1'b1;
      cyc();
      print_regs = 1'b0;
      cyc();
      checks++;
      if (print_idx !== 2'd1) begin errors++; $display("FAIL dr_idx got=%0d exp=1", print_idx); end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks += 4;
      if (ready !== 1'b1)       begin errors++; $display("FAIL dr_ready got=%b exp=1", ready); end
      if (depth !== 3'd0)       begin errors++; $display("FAIL dr_depth got=%0d exp=0", depth); end
      if (print_valid !== 1'b0) begin errors++; $display("FAIL dr_pv got=%b exp=0", print_valid); end
      if (print_done !== 1'b0)  begin errors++; $display("FAIL dr_pd got=%b exp=0", print_done); end
      cyc();
      checks++;
      if (print_done !== 1'b0) begin errors++; $display("FAIL dr_pd2 got=%b exp=0", print_done); end
      print_regs = 1'b1;
      cyc();
      print_regs = 1'b0;
      checks += 3;
      if (print_done !== 1'b1)  begin errors++; $display("FAIL de_done got=%b exp=1", print_done); end
      if (print_valid !== 1'b0) begin errors++; $display("FAIL de_pv got=%b exp=0", print_valid); end
      if (ready !== 1'b0)       begin errors++; $display("FAIL de_ready got=%b exp=0", ready); end
      cyc();
      checks += 2;
      if (print_done !== 1'b0) begin errors++; $display("FAIL de_pulse got=%b exp=0", print_done); end
      if (ready !== 1'b1)      begin errors++; $display("FAIL de_rdyback got=%b exp=1", ready); end
   endtask

   // print_regs with a push on an empty stack dumps the freshly pushed entry.
   task automatic test_back_to_back();
      do_reset();
      jal = 1'b1; write_data_ra = 3'd5; print_regs = 1'b1;
      cyc();
      jal = 1'b0; print_regs = 1'b0;
      checks += 4;
      if (print_valid !== 1'b1) begin errors++; $display("FAIL bb_pv got=%b exp=1", print_valid); end
      if (print_idx !== 2'd0)   begin errors++; $display("FAIL bb_idx got=%0d exp=0", print_idx); end
      if (print_data !== 3'd5)  begin errors++; $display("FAIL bb_data got=%0d exp=5", print_data); end
      if (depth !== 3'd1)       begin errors++; $display("FAIL bb_depth got=%0d exp=1", depth); end
      cyc();
      checks++;
      if (print_done !== 1'b1) begin errors++; $display("FAIL bb_done got=%b exp=1", print_done); end
      cyc();
      checks += 2;
      if (ready !== 1'b1)       begin errors++; $display("FAIL bb_ready got=%b exp=1", ready); end
      if (print_data !== 3'd0)  begin errors++; $display("FAIL bb_pdidle got=%0d exp=0", print_data); end
   endtask

   initial begin
      reset = 1'b1; jal = 1'b0; jr = 1'b0; print_regs = 1'b0; write_data_ra = '0;
      #1;
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_tail_call();
      test_dump();
      test_dump_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
